// File: rtl/uart_pkg.sv
// Shared UART definitions: autobaud FSM states, divisor width, calibration
// constants and the default-divisor helper also used by the baud generator.
package uart_pkg;

    localparam int DIV_W     = 16;
    localparam int CAL_EDGES = 4;   // falling edges after the start bit of 0x55
    localparam int CAL_SHIFT = 7;   // 8 bit times * 16 ticks per bit
    localparam int CAL_ROUND = 64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_START,
        ST_MEASURE,
        ST_CHECK,
        ST_APPLY
    } autobaud_state_t;

    function automatic int calc_div(input int clk_freq, input int baud);
        return clk_freq / (baud * 16);
    endfunction

endpackage

// File: rtl/rx_sync_fall.sv
// RX synchronizer: two flops into the clock domain plus a one-cycle falling-edge
// pulse. Every edge sees the same latency, so intervals between edges are exact.
module rx_sync_fall (
    input  logic clk,
    input  logic rst,
    input  logic rx,
    output logic fall
);

    logic meta;
    logic cur;
    logic prev;

    // Reset to the idle-high line level so reset release does not fake an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b1;
            cur  <= 1'b1;
            prev <= 1'b1;
        end else begin
            meta <= rx;
            cur  <= meta;
            prev <= cur;
        end
    end

    assign fall = prev & ~cur;

endmodule

// File: rtl/uart_autobaud_ctrl.sv
// Holds the active 16x baud divisor; loads it from host writes or from a
// measured 0x55 calibration byte on the RX line.
module uart_autobaud_ctrl
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 1_600_000,
    parameter int DEF_BAUD = 5000,
    parameter int DIV_W    = uart_pkg::DIV_W,
    parameter int CNT_W    = 24,
    parameter int MIN_DIV  = 2,
    parameter int TIMEOUT  = 2**CNT_W - 1
) (
    input  logic             iClk,
    input  logic             iRst,
    input  logic             iRx,
    input  logic             iAutoStart,
    input  logic             iCfgWe,
    input  logic [DIV_W-1:0] iCfgDiv,
    output logic [DIV_W-1:0] oDiv,
    output logic             oDivLoad,
    output logic             oBusy,
    output logic             oLocked,
    output logic             oErr,
    output autobaud_state_t  dbg_state
);

    localparam int               CW        = CNT_W + 2;
    localparam logic [DIV_W-1:0] DEF_DIV   = DIV_W'(calc_div(CLK_FREQ, DEF_BAUD));
    localparam logic [DIV_W-1:0] MIN_DIV_V = DIV_W'(MIN_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CW-1:0]    TIMEOUT_V = CW'(TIMEOUT);

    autobaud_state_t  state;
    logic             fall;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [2:0]       edge_cnt;
    logic [CNT_W-1:0] i0;
    logic [CNT_W-1:0] t_meas;
    logic [CW-1:0]    t_ext;
    logic [CW-1:0]    i0_x4;
    logic [CW-1:0]    div_full;
    logic [CW-1:0]    diff;
    logic [CW-1:0]    tol;
    logic             cal_bad;

    rx_sync_fall u_rx_sync (
        .clk  (iClk),
        .rst  (iRst),
        .rx   (iRx),
        .fall (fall)
    );

    assign cnt_inc   = (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
    assign dbg_state = state;

    // The first interval spans 2 bit times and T spans 8, so 4*I0 should match T.
    always_comb begin
        t_ext    = CW'(t_meas);
        i0_x4    = CW'(i0) << 2;
        div_full = (t_ext + CW'(CAL_ROUND)) >> CAL_SHIFT;
        diff     = (i0_x4 >= t_ext) ? (i0_x4 - t_ext) : (t_ext - i0_x4);
        tol      = t_ext >> 2;
        cal_bad  = (div_full < CW'(MIN_DIV)) ||
                   (div_full >= (CW'(1) << DIV_W)) ||
                   (diff > tol);
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            edge_cnt <= '0;
            i0       <= '0;
            t_meas   <= '0;
            oDiv     <= DEF_DIV;
            oDivLoad <= 1'b0;
            oBusy    <= 1'b0;
            oLocked  <= 1'b0;
            oErr     <= 1'b0;
        end else begin
            oDivLoad <= 1'b0;
            if (iCfgWe) begin
                // Host write overrides everything, including a same-cycle start.
                oDiv     <= (iCfgDiv < MIN_DIV_V) ? MIN_DIV_V : iCfgDiv;
                oDivLoad <= 1'b1;
                oLocked  <= 1'b0;
                oErr     <= 1'b0;
                oBusy    <= 1'b0;
                state    <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (iAutoStart) begin
                            state   <= ST_WAIT_START;
                            oBusy   <= 1'b1;
                            oLocked <= 1'b0;
                            oErr    <= 1'b0;
                            cnt     <= '0;
                        end
                    end
                    ST_WAIT_START: begin
                        if (fall) begin
                            cnt      <= '0;
                            edge_cnt <= '0;
                            state    <= ST_MEASURE;
                        end else if (CW'(cnt) >= TIMEOUT_V) begin
                            oErr  <= 1'b1;
                            oBusy <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    ST_MEASURE: begin
                        cnt <= cnt_inc;
                        if (fall) begin
                            edge_cnt <= edge_cnt + 3'd1;
                            if (edge_cnt == 3'd0) begin
                                i0 <= cnt_inc;
                            end
                            if (edge_cnt == 3'(CAL_EDGES - 1)) begin
                                t_meas <= cnt_inc;
                                state  <= ST_CHECK;
                            end
                        end else if (CW'(cnt) >= TIMEOUT_V) begin
                            oErr  <= 1'b1;
                            oBusy <= 1'b0;
                            state <= ST_IDLE;
                        end
                    end
                    ST_CHECK: begin
                        if (cal_bad) begin
                            oErr  <= 1'b1;
                            oBusy <= 1'b0;
                            state <= ST_IDLE;
                        end else begin
                            state <= ST_APPLY;
                        end
                    end
                    ST_APPLY: begin
                        oDiv     <= div_full[DIV_W-1:0];
                        oDivLoad <= 1'b1;
                        oLocked  <= 1'b1;
                        oBusy    <= 1'b0;
                        state    <= ST_IDLE;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: autobaud and host-write vector tables, glitch,
// abort, reset and timeout sequences, with a divisor-load scoreboard.
module tb_uart_autobaud_ctrl;
    import uart_pkg::*;

    logic            clk;
    logic            rst;
    logic            rx;
    logic            auto_start;
    logic            cfg_we;
    logic [15:0]     cfg_div;
    logic [15:0]     div;
    logic            div_load;
    logic            busy;
    logic            locked;
    logic            err;
    autobaud_state_t state;
    logic [15:0]     to_div;
    logic            to_div_load;
    logic            to_busy;
    logic            to_locked;
    logic            to_err;
    autobaud_state_t to_state;

    int checks = 0;
    int errors = 0;
    logic [15:0] exp_q[$];

    uart_autobaud_ctrl dut (
        .iClk(clk), .iRst(rst), .iRx(rx), .iAutoStart(auto_start),
        .iCfgWe(cfg_we), .iCfgDiv(cfg_div), .oDiv(div), .oDivLoad(div_load),
        .oBusy(busy), .oLocked(locked), .oErr(err), .dbg_state(state)
    );

    // Same stimulus, short timeout; only observed in the timeout sequence.
    uart_autobaud_ctrl #(.TIMEOUT(1000)) dut_to (
        .iClk(clk), .iRst(rst), .iRx(rx), .iAutoStart(auto_start),
        .iCfgWe(cfg_we), .iCfgDiv(cfg_div), .oDiv(to_div), .oDivLoad(to_div_load),
        .oBusy(to_busy), .oLocked(to_locked), .oErr(to_err), .dbg_state(to_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Every divisor-load pulse must match the next expected divisor.
    always @(negedge clk) begin
        if (!rst && div_load) begin
            if (exp_q.size() == 0) begin
                check("sb_unexpected_load", 32'(div), 32'hFFFF_FFFF);
            end else begin
                check("sb_load_div", 32'(div), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        auto_start = 1'b1;
        @(negedge clk);
        auto_start = 1'b0;
    endtask

    task automatic host_write(input logic [15:0] v, input logic with_start, input logic [15:0] exp);
        @(negedge clk);
        exp_q.push_back(exp);
        cfg_we     = 1'b1;
        cfg_div    = v;
        auto_start = with_start;
        @(negedge clk);
        cfg_we     = 1'b0;
        auto_start = 1'b0;
    endtask

    // 8N1 byte; each bit boundary is displaced by up to +/-jit cycles.
    task automatic send_byte(input logic [7:0] b, input int p, input int jit);
        int j[11];
        logic lvl;
        for (int k = 0; k < 11; k++) begin
            j[k] = (k == 0 || k == 10) ? 0 : int'($urandom_range(0, 2 * jit)) - jit;
        end
        for (int k = 0; k < 10; k++) begin
            lvl = (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
            rx = lvl;
            repeat (p + j[k+1] - j[k]) @(negedge clk);
        end
        rx = 1'b1;
    endtask

    task automatic wait_idle(input int budget, output logic ok);
        ok = 1'b0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clk);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    typedef struct {
        int          period;
        int          jitter;
        logic [15:0] exp_div;
    } ab_vec_t;

    typedef struct {
        logic [15:0] cfg;
        logic        start;
        logic [15:0] exp_div;
    } wr_vec_t;

    ab_vec_t ab_tab[4];
    wr_vec_t wr_tab[7];

    initial begin
        logic ok;
        int   waited;

        ab_tab[0] = '{160, 0, 16'd10};
        ab_tab[1] = '{150, 2, 16'd9};
        ab_tab[2] = '{40,  0, 16'd3};
        ab_tab[3] = '{256, 1, 16'd16};
        wr_tab[0] = '{16'd33,     1'b0, 16'd33};
        wr_tab[1] = '{16'd1,      1'b0, 16'd2};
        wr_tab[2] = '{16'd0,      1'b0, 16'd2};
        wr_tab[3] = '{16'd2,      1'b0, 16'd2};
        wr_tab[4] = '{16'd1000,   1'b1, 16'd1000};
        wr_tab[5] = '{16'hFFFF,   1'b0, 16'hFFFF};
        wr_tab[6] = '{16'd3,      1'b0, 16'd3};

        rst = 1'b1; rx = 1'b1; auto_start = 1'b0; cfg_we = 1'b0; cfg_div = '0;
        do_reset();
        repeat (4) @(negedge clk);
        check("rst_div", 32'(div), 32'd20);
        check("rst_load", 32'(div_load), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_locked", 32'(locked), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_state", 32'(state), 32'(ST_IDLE));

        // Glitch train: 4-cycle falls give T=16, which rounds to divisor 0.
        pulse_start();
        repeat (5) @(negedge clk);
        repeat (8) begin
            rx = 1'b0;
            repeat (2) @(negedge clk);
            rx = 1'b1;
            repeat (2) @(negedge clk);
        end
        wait_idle(100, ok);
        check("glitch_done", 32'(ok), 32'd1);
        check("glitch_err", 32'(err), 32'd1);
        check("glitch_div", 32'(div), 32'd20);
        check("glitch_locked", 32'(locked), 32'd0);

        foreach (ab_tab[i]) begin
            pulse_start();
            check("ab_busy", 32'(busy), 32'd1);
            check("ab_err_cleared", 32'(err), 32'd0);
            repeat (10) @(negedge clk);
            exp_q.push_back(ab_tab[i].exp_div);
            send_byte(8'h55, ab_tab[i].period, ab_tab[i].jitter);
            wait_idle(200, ok);
            check("ab_done", 32'(ok), 32'd1);
            check("ab_div", 32'(div), 32'(ab_tab[i].exp_div));
            check("ab_locked", 32'(locked), 32'd1);
            check("ab_err", 32'(err), 32'd0);
        end

        foreach (wr_tab[i]) begin
            host_write(wr_tab[i].cfg, wr_tab[i].start, wr_tab[i].exp_div);
            check("wr_div", 32'(div), 32'(wr_tab[i].exp_div));
            check("wr_load", 32'(div_load), 32'd1);
            check("wr_busy", 32'(busy), 32'd0);
            check("wr_locked", 32'(locked), 32'd0);
            check("wr_state", 32'(state), 32'(ST_IDLE));
        end

        // Host write lands in the middle of a measurement and aborts it.
        pulse_start();
        repeat (10) @(negedge clk);
        fork
            send_byte(8'h55, 160, 0);
            begin
                repeat (500) @(negedge clk);
                check("abort_busy_before", 32'(busy), 32'd1);
                host_write(16'd33, 1'b0, 16'd33);
                check("abort_div", 32'(div), 32'd33);
                check("abort_busy", 32'(busy), 32'd0);
                check("abort_state", 32'(state), 32'(ST_IDLE));
            end
        join
        repeat (20) @(negedge clk);
        check("abort_div_hold", 32'(div), 32'd33);
        check("abort_locked", 32'(locked), 32'd0);

        // Timeout with RX idle, seen on the short-timeout instance.
        do_reset();
        pulse_start();
        waited = 0;
        ok = 1'b0;
        for (int c = 0; c < 1200; c++) begin
            @(negedge clk);
            waited++;
            if (to_err) begin
                ok = 1'b1;
                break;
            end
        end
        check("to_err", 32'(ok), 32'd1);
        check("to_wait_range", 32'(waited >= 990 && waited <= 1010), 32'd1);
        check("to_busy", 32'(to_busy), 32'd0);
        pulse_start();
        check("to_err_cleared", 32'(to_err), 32'd0);
        check("to_busy_again", 32'(to_busy), 32'd1);

        // Main instance is still waiting for a start bit; reset must clear it.
        check("mid_busy", 32'(busy), 32'd1);
        do_reset();
        @(negedge clk);
        check("mid_rst_div", 32'(div), 32'd20);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_state", 32'(state), 32'(ST_IDLE));

        check("sb_drain", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_autobaud_ctrl.md
Name: uart_autobaud_ctrl

Overview:
Configuration controller for the programmable 16x baud tick generator in the UART path. It holds the active 16x divisor and drives it to the generator, either from host register writes or from automatic measurement of a 0x55 ('U') calibration byte on the RX line. It sits between the host config bus, the raw RX pin and the baud generator's divisor-load port.

Parameters:
CLK_FREQ, 1_600_000, system clock frequency in Hz
DEF_BAUD, 5000, baud rate applied at reset
DIV_W, 16, divisor width
CNT_W, 24, measurement counter width
MIN_DIV, 2, smallest legal measured divisor
TIMEOUT, 2**CNT_W-1, cycles without a required edge before abort

Ports:
iClk  in  1  system clock
iRst  in  1  synchronous active-high reset
iRx  in  1  raw asynchronous RX line (idle high)
iAutoStart  in  1  single-cycle pulse: begin autobaud measurement
iCfgWe  in  1  single-cycle pulse: load iCfgDiv as divisor
iCfgDiv  in  DIV_W  host-supplied divisor
oDiv  out  DIV_W  active 16x divisor (baud generator counts 0..oDiv-1)
oDivLoad  out  1  one-cycle pulse when oDiv changes
oBusy  out  1  measurement in progress
oLocked  out  1  last autobaud succeeded; cleared on start, error or host write
oErr  out  1  sticky: last autobaud failed; cleared on next iAutoStart or iCfgWe

Behaviour:
- Reset: oDiv = DEF_DIV = CLK_FREQ/(DEF_BAUD*16) (compile-time, 20 with defaults); oDivLoad=0, oBusy=0, oLocked=0, oErr=0; FSM=IDLE; counters 0.
- RX path: 2-flop synchronizer, then one register for falling-edge detect (fall = prev & ~cur). All edges incur the same 3-cycle delay, so measurements are unaffected.
- FSM states: IDLE, WAIT_START, MEASURE, CHECK, APPLY.
- IDLE: iAutoStart -> WAIT_START. Set oBusy=1, clear oLocked and oErr.
- WAIT_START: first falling edge (start bit) clears cnt and sets edgeCnt=0, then -> MEASURE. If no edge within TIMEOUT cycles: oErr=1, -> IDLE.
- MEASURE: cnt increments every cycle. On each falling edge, edgeCnt++. On edgeCnt 0->1, latch cnt+1 as first interval (I0 = 2 bit times). On the 4th edge after start (edge at bit 8), latch T = cnt+1 (8 bit times) and go to CHECK. If cnt reaches TIMEOUT: oErr=1, -> IDLE.
- CHECK (1 cycle):
  - div = (T + 64) >> 7, rounded T/128.
  - Error if div < MIN_DIV, div >= 2**DIV_W, or |4*I0 - T| > T>>2 (consistency within 25%).
  - Error -> oErr=1, -> IDLE, oDiv unchanged. Else -> APPLY.
- APPLY: oDiv <= div, oDivLoad=1 for this cycle, oLocked=1, oBusy=0, -> IDLE.
- Host write: iCfgWe in any state loads oDiv <= iCfgDiv next cycle. oDivLoad pulses, oLocked=0, oErr=0. An in-flight measurement is aborted to IDLE with oBusy=0. iCfgDiv < MIN_DIV is clamped to MIN_DIV.
- iCfgWe and iAutoStart in the same cycle: the write wins and autostart is ignored.
- iAutoStart while oBusy=1 is ignored.
- Reset mid-measurement returns everything to reset values.
- Arithmetic: cnt saturates and never wraps. All compares are unsigned, at CNT_W+2 bits.

Decomposition:
- Shared package uart_pkg holds:
  - the state enum autobaud_state_t
  - DIV_W
  - the calibration constants: CAL_EDGES=4, CAL_SHIFT=7, CAL_ROUND=64
  - the function computing DEF_DIV from CLK_FREQ and baud (shared with baud_rate_gen)
- One sub-module, rx_sync_fall: 2-flop synchronizer plus falling-edge pulse, reusable by uart_rx.

Test Plan:
- Reset, 4 idle cycles -> oDiv=20, oDivLoad=0, oBusy=0, oLocked=0, oErr=0.
- iAutoStart, then 0x55 at 160 cycles/bit (8N1) -> T=1280, oDiv=10, one oDivLoad pulse, oLocked=1, oBusy=0. The baud generator then gives an oTick16x period of 10 cycles.
- 0x55 at 150 cycles/bit with ±2-cycle jitter per edge -> oDiv=(1200+64)>>7=9, oLocked=1.
- Glitch train (RX low 2 / high 2 cycles, repeated) after iAutoStart -> T=16, div=0 -> oErr=1, oDiv stays 20, no oDivLoad.
- iAutoStart with RX held high, TIMEOUT set to 1000 -> after about 1000 cycles oErr=1, oBusy=0. A second iAutoStart clears oErr.
- iCfgWe with iCfgDiv=33 in the middle of a measurement -> oDiv=33 next cycle, oDivLoad pulses once, oBusy=0. Remaining RX edges cause no further change. A write of iCfgDiv=1 yields oDiv=2.
